seg7_num_display: RTL and testbench

- Parametrised numeric display engine for the board wrapper. It takes a DATA_W-bit value, normally the SW_DISP switch field or an MMIO display register.
- Renders the value on N_DIGITS active-low seven-segment digits as unsigned decimal, signed decimal or hex.
- Decimal conversion uses a sequential double-dabble converter. Leading-zero blanking and overflow indication are supported.
- Replaces fixed-width combinational hex decoding in the wrapper.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_encode.sv | 32 +++
 rtl/seg7_num_display.sv | 184 ++++++++++++++++++
 tb/tb_seg7_num_display.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment numeric display engine.
// Holds the controller state and display-mode encodings, the fixed segment patterns and digit-count helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        SHIFT  = 2'b10,
        FORMAT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_UDEC    = 2'b00,
        MODE_SDEC    = 2'b01,
        MODE_HEX     = 2'b10,
        MODE_HEX_ALT = 2'b11
    } mode_t;

    // Segment patterns are active-low, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Three binary bits never need more than one decimal digit.
    function automatic int bcd_digits(input int data_w);
        return (data_w + 2) / 3;
    endfunction

    function automatic int hex_digits(input int data_w);
        return (data_w + 3) / 4;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit to seven-segment encoder, active-low, bit order gfedcba.
// Covers decimal digits and the hex letters A b C d E F.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg7_num_display.sv
// Numeric display engine: renders a DATA_W-bit value on N_DIGITS seven-segment digits
// as unsigned decimal, signed decimal or hex, with a sequential double-dabble converter.
module seg7_num_display
    import seg7_pkg::*;
#(
    parameter int DATA_W   = 17,
    parameter int N_DIGITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [1:0]            i_mode,
    input  logic                  i_blank_lz,
    output logic [7*N_DIGITS-1:0] o_seg,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int BCD_D = bcd_digits(DATA_W);
    localparam int HEX_D = hex_digits(DATA_W);
    localparam int SRC_D = (BCD_D > HEX_D) ? BCD_D : HEX_D;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t state;
    state_t state_next;

    logic                  snap_valid;
    logic [DATA_W-1:0]     snap_data;
    logic [1:0]            snap_mode;
    logic                  snap_blank;

    logic [DATA_W-1:0]     mag;
    logic [4*BCD_D-1:0]    bcd;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;
    logic [7*N_DIGITS-1:0] seg_q;
    logic                  overflow_q;

    mode_t                 mode;
    logic                  is_hex;
    logic                  start;
    logic                  neg_load;
    logic [DATA_W-1:0]     mag_load;
    logic [4*BCD_D-1:0]    bcd_adj;
    logic [4*SRC_D-1:0]    src;
    logic [7*N_DIGITS-1:0] seg_enc;
    logic [7*N_DIGITS-1:0] seg_fmt;
    logic                  overflow_fmt;

    // All conversion decisions use the snapshot, so inputs moving mid-conversion are ignored.
    assign mode   = mode_t'(snap_mode);
    assign is_hex = (mode == MODE_HEX) || (mode == MODE_HEX_ALT);
    assign start  = (state == IDLE) &&
                    (!snap_valid ||
                     ({i_data, i_mode, i_blank_lz} != {snap_data, snap_mode, snap_blank}));

    // Two's complement negate; the most-negative value maps onto itself, which is its correct magnitude.
    assign neg_load = (mode == MODE_SDEC) && snap_data[DATA_W-1];
    assign mag_load = neg_load ? (~snap_data + DATA_W'(1)) : snap_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = is_hex ? FORMAT : SHIFT;
            SHIFT:   if (cnt == CNT_W'(DATA_W - 1)) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            snap_valid <= 1'b0;
            snap_data  <= '0;
            snap_mode  <= '0;
            snap_blank <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            seg_q      <= '1;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_valid <= 1'b1;
                        snap_data  <= i_data;
                        snap_mode  <= i_mode;
                        snap_blank <= i_blank_lz;
                    end
                end
                LOAD: begin
                    mag <= mag_load;
                    neg <= neg_load;
                    bcd <= '0;
                    cnt <= '0;
                end
                SHIFT: begin
                    bcd <= {bcd_adj[4*BCD_D-2:0], mag[DATA_W-1]};
                    mag <= {mag[DATA_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                FORMAT: begin
                    seg_q      <= seg_fmt;
                    overflow_q <= overflow_fmt;
                end
                default: ;
            endcase
        end
    end

    // Hex digits come straight from the unshifted magnitude; decimal digits from the BCD register.
    always_comb begin
        src = '0;
        if (is_hex) begin
            src[DATA_W-1:0] = mag;
        end else begin
            src[4*BCD_D-1:0] = bcd;
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic [3:0] value;
        if (k < SRC_D) begin : g_src
            assign value = src[4*k +: 4];
        end else begin : g_pad
            assign value = 4'd0;
        end
        seg7_encode u_encode (
            .value (value),
            .seg   (seg_enc[7*k +: 7])
        );
    end

    // The sign consumes one digit position, so negative values have one fewer magnitude digit.
    always_comb begin
        int msd;
        int limit;
        msd          = 0;
        limit        = neg ? N_DIGITS - 1 : N_DIGITS;
        seg_fmt      = '1;
        overflow_fmt = 1'b0;
        for (int i = 0; i < SRC_D; i++) begin
            if (src[4*i +: 4] != 4'd0) msd = i;
        end
        overflow_fmt = (msd >= limit);
        for (int k = 0; k < N_DIGITS; k++) begin
            if (overflow_fmt) begin
                seg_fmt[7*k +: 7] = SEG_DASH;
            end else if (snap_blank && (k > msd)) begin
                seg_fmt[7*k +: 7] = (neg && (k == msd + 1)) ? SEG_DASH : SEG_BLANK;
            end else if (!snap_blank && neg && (k == N_DIGITS - 1)) begin
                seg_fmt[7*k +: 7] = SEG_DASH;
            end else begin
                seg_fmt[7*k +: 7] = seg_enc[7*k +: 7];
            end
        end
    end

    assign o_seg      = seg_q;
    assign o_overflow = overflow_q;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_seg7_num_display.sv
// Self-checking bench for seg7_num_display: an 8-digit and a 4-digit instance share stimulus,
// a latency-level reference model is compared every cycle, and literal expectations pin the model.
module tb_seg7_num_display;

    localparam int DATA_W = 17;
    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_DA = 7'b0111111;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_4  = 7'b0011001;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_6  = 7'b0000010;
    localparam logic [6:0] S_7  = 7'b1111000;
    localparam logic [6:0] S_9  = 7'b0010000;
    localparam logic [6:0] S_F  = 7'b0001110;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data;
    logic [1:0]        mode;
    logic              blank_lz;
    logic [55:0]       seg8;
    logic              busy8;
    logic              ovf8;
    logic [27:0]       seg4;
    logic              busy4;
    logic              ovf4;

    int n_vec = 0;
    int n_err = 0;
    logic check_en = 1'b0;

    seg7_num_display #(.DATA_W(DATA_W), .N_DIGITS(8)) dut8 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_data     (data),
        .i_mode     (mode),
        .i_blank_lz (blank_lz),
        .o_seg      (seg8),
        .o_busy     (busy8),
        .o_overflow (ovf8)
    );

    seg7_num_display #(.DATA_W(DATA_W), .N_DIGITS(4)) dut4 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_data     (data),
        .i_mode     (mode),
        .i_blank_lz (blank_lz),
        .o_seg      (seg4),
        .o_busy     (busy4),
        .o_overflow (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Returns {overflow, segments} for an nd-digit display; unused upper digits are zero.
    function automatic logic [56:0] render(input logic [DATA_W-1:0] d, input logic [1:0] m,
                                           input logic b, input int nd);
        logic [56:0] out;
        logic        neg;
        logic        ovf;
        logic [6:0]  s;
        int mag, base, ndig, lim, q;
        neg  = (m == 2'b01) && d[DATA_W-1];
        mag  = int'({15'b0, d});
        if (neg) mag = (1 << DATA_W) - mag;
        base = m[1] ? 16 : 10;
        ndig = 1;
        q    = mag / base;
        while (q > 0) begin
            ndig++;
            q = q / base;
        end
        lim = neg ? nd - 1 : nd;
        ovf = (ndig > lim);
        out = '0;
        q   = mag;
        for (int k = 0; k < nd; k++) begin
            if (ovf) s = S_DA;
            else if (b && k >= ndig) s = (neg && k == ndig) ? S_DA : S_BL;
            else if (!b && neg && k == nd - 1) s = S_DA;
            else s = seg_of(q % base);
            out[7*k +: 7] = s;
            q = q / base;
        end
        out[56] = ovf;
        return out;
    endfunction

    // Reference timing: a conversion starts when the idle engine sees new inputs and the
    // display switches to the rendered value after the documented latency.
    int          m_cnt = 0;
    logic        m_valid = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic [1:0]  m_mode = '0;
    logic        m_blank = 1'b0;
    logic [56:0] exp8 = {1'b0, {56{1'b1}}};
    logic [56:0] exp4 = {1'b0, {56{1'b1}}};
    logic [56:0] pend8 = '0;
    logic [56:0] pend4 = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            exp8    <= {1'b0, {56{1'b1}}};
            exp4    <= {1'b0, {56{1'b1}}};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                exp8 <= pend8;
                exp4 <= pend4;
            end
        end else if (!m_valid || data !== m_data || mode !== m_mode || blank_lz !== m_blank) begin
            m_valid <= 1'b1;
            m_data  <= data;
            m_mode  <= mode;
            m_blank <= blank_lz;
            m_cnt   <= mode[1] ? 2 : DATA_W + 2;
            pend8   <= render(data, mode, blank_lz, 8);
            pend4   <= render(data, mode, blank_lz, 4);
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("model_seg8",  64'(seg8),  64'(exp8[55:0]));
            check_output("model_ovf8",  64'(ovf8),  64'(exp8[56]));
            check_output("model_busy8", 64'(busy8), 64'(m_cnt != 0));
            check_output("model_seg4",  64'(seg4),  64'(exp4[27:0]));
            check_output("model_ovf4",  64'(ovf4),  64'(exp4[56]));
            check_output("model_busy4", 64'(busy4), 64'(m_cnt != 0));
        end
    end

    task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic [1:0] m, input logic b);
        @(negedge clk);
        data     = d;
        mode     = m;
        blank_lz = b;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy8 === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 200) check_output("idle_timeout", 64'(busy8), 64'(0));
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [1:0]        m;
        logic              b;
    } vec_t;

    vec_t tbl [8] = '{
        '{17'd0,      2'b00, 1'b1},
        '{17'd0,      2'b00, 1'b0},
        '{17'h10000,  2'b01, 1'b1},
        '{17'd130073, 2'b01, 1'b1},
        '{17'd130072, 2'b01, 1'b0},
        '{17'h1ABCD,  2'b11, 1'b1},
        '{17'h0FFFF,  2'b10, 1'b1},
        '{17'h0FFFF,  2'b01, 1'b0}
    };

    initial begin
        int cycles;
        int n;
        logic [55:0] prev;
        reset    = 1'b1;
        data     = 17'd64;
        mode     = 2'b00;
        blank_lz = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_seg",  64'(seg8),  64'({56{1'b1}}));
        check_output("reset_busy", 64'(busy8), 64'(0));
        check_output("reset_ovf",  64'(ovf8),  64'(0));
        check_en = 1'b1;
        reset    = 1'b0;

        wait_idle(cycles);
        check_output("dec_busy_cycles", 64'(cycles), 64'(19));
        check_output("lit_64", 64'(seg8), 64'({{6{S_BL}}, S_6, S_4}));
        check_output("lit_64_ovf", 64'(ovf8), 64'(0));

        apply_stimulus(17'd2047, 2'b10, 1'b0);
        wait_idle(cycles);
        check_output("hex_busy_cycles", 64'(cycles), 64'(2));
        check_output("lit_7FF", 64'(seg8), 64'({{5{S_0}}, S_7, S_F, S_F}));

        apply_stimulus(17'h1FFFF, 2'b01, 1'b1);
        wait_idle(cycles);
        check_output("lit_m1_blank", 64'(seg8), 64'({{6{S_BL}}, S_DA, S_1}));

        apply_stimulus(17'h1FFFF, 2'b01, 1'b0);
        wait_idle(cycles);
        check_output("lit_m1_pad", 64'(seg8), 64'({S_DA, {6{S_0}}, S_1}));

        apply_stimulus(17'd99999, 2'b00, 1'b1);
        wait_idle(cycles);
        check_output("lit_ovf4_seg", 64'(seg4), 64'({4{S_DA}}));
        check_output("lit_ovf4_flag", 64'(ovf4), 64'(1));

        apply_stimulus(17'd9999, 2'b00, 1'b1);
        wait_idle(cycles);
        check_output("lit_9999_seg", 64'(seg4), 64'({4{S_9}}));
        check_output("lit_9999_flag", 64'(ovf4), 64'(0));

        apply_stimulus(17'd9999, 2'b00, 1'b1);
        wait_idle(cycles);
        check_output("no_restart_same_input", 64'(cycles), 64'(0));

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].d, tbl[i].m, tbl[i].b);
            wait_idle(cycles);
        end

        apply_stimulus(17'd1000, 2'b00, 1'b1);
        prev = seg8;
        repeat (5) @(negedge clk);
        data = 17'd2047;
        n = 0;
        while (seg8 === prev && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("first_update_1000", 64'(seg8), 64'({{4{S_BL}}, S_1, S_0, S_0, S_0}));
        prev = seg8;
        n = 0;
        while (seg8 === prev && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("final_2047", 64'(seg8), 64'({{4{S_BL}}, S_2, S_0, S_4, S_7}));
        wait_idle(cycles);

        apply_stimulus(17'd12345, 2'b00, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort_busy", 64'(busy8), 64'(0));
        check_output("abort_seg", 64'(seg8), 64'({56{1'b1}}));
        n = 0;
        while (seg8 === {56{1'b1}} && n < DATA_W + 3) begin
            @(negedge clk);
            n++;
        end
        check_output("recover_cycles", 64'(n), 64'(DATA_W + 3));
        check_output("recover_12345", 64'(seg8), 64'({{3{S_BL}}, S_1, S_2, S_3, S_4, S_5}));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
